axil_regfile_slave: RTL

Parametrised AXI4-Lite slave that terminates all five channels into an internal register bank.
- Successor to the current pass-through AXI4-Lite top: adds real address decode, WSTRB byte-lane writes, OKAY/SLVERR responses, and independent AW/W arrival ordering.
- Sits behind the interconnect as the generic control/status register target.

---
 rtl/axil_regfile_slave_pkg.sv | 23 ++
 rtl/axil_regfile_slave_if.sv | 49 ++++
 rtl/axil_regfile_slave_wstrb_merge.sv | 28 ++
 rtl/axil_regfile_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regfile_slave_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register-file slave and its helpers.
//   RESP_OKAY / RESP_SLVERR : BRESP/RRESP encodings
//   wstate_e                : write-path FSM states
//   rstate_e                : read-path FSM states
// ---------------------------------------------------------------------------
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axil_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// axil_regfile_slave_if
// AXI4-Lite bundle carrying all five channels.
//   Parameters : ADDR_WIDTH, DATA_WIDTH
//   master     : drives AW/W/AR requests and BREADY/RREADY
//   slave      : drives AWREADY/WREADY/ARREADY and the B/R responses
// ---------------------------------------------------------------------------
interface axil_regfile_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [2:0]                AWPROT;

  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;

  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;

  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [2:0]                ARPROT;

  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axil_regfile_slave_wstrb_merge.sv
// ---------------------------------------------------------------------------
// axil_wstrb_merge
// Combinational byte-lane merge: every lane whose strobe bit is set takes the
// new write data, every other lane keeps the old register contents.
//   oldData_i    : current register value
//   wData_i      : write data
//   wStrb_i      : byte enables, one per 8-bit lane
//   mergedData_o : resulting register value
// ---------------------------------------------------------------------------
module axil_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   oldData_i,
  input  logic [DATA_WIDTH-1:0]   wData_i,
  input  logic [DATA_WIDTH/8-1:0] wStrb_i,
  output logic [DATA_WIDTH-1:0]   mergedData_o
);

  always_comb begin
    mergedData_o = oldData_i;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (wStrb_i[i]) begin
        mergedData_o[i*8 +: 8] = wData_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// ---------------------------------------------------------------------------
// axil_regfile_slave
// AXI4-Lite slave terminating all five channels into a bank of NUM_REGS
// registers, with address decode, WSTRB byte-lane writes and OKAY/SLVERR
// responses. Write and read paths are independent FSMs.
//   ACLK    : clock
//   ARESETn : asynchronous active-low reset
//   bus     : AXI4-Lite slave modport (AW, W, B, AR, R channels)
// Parameters: ADDR_WIDTH, DATA_WIDTH (32 or 64), NUM_REGS (power of two,
// >= 2), RESET_VAL.
// Optional build macro AXIL_PROT_CHECK_EN: the upper half of the register
// bank becomes privileged and needs PROT[0]=1, otherwise SLVERR.
// ---------------------------------------------------------------------------
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  axil_regfile_slave_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write path state
  wstate_e               wState_q, wState_d;
  logic                  awReady_q, awReady_d;
  logic                  wReady_q, wReady_d;
  logic                  awHave_q, awHave_d;
  logic                  wHave_q, wHave_d;
  logic                  bValid_q, bValid_d;
  logic [1:0]            bResp_q, bResp_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d;
  logic [STRB_W-1:0]     wStrb_q, wStrb_d;

  // Read path state
  rstate_e               rState_q, rState_d;
  logic                  arReady_q, arReady_d;
  logic                  arHave_q, arHave_d;
  logic                  rValid_q, rValid_d;
  logic [1:0]            rResp_q, rResp_d;
  logic [DATA_WIDTH-1:0] rData_q, rData_d;
  logic [ADDR_WIDTH-1:0] arAddr_q, arAddr_d;

  logic                  regWe;
  logic [IDX_W-1:0]      wIdx;
  logic [IDX_W-1:0]      rIdx;
  logic                  wOk;
  logic                  rOk;
  logic [DATA_WIDTH-1:0] mergedData;

  // An address is in range when every bit above the register index is zero,
  // which is the same as (addr >> LSB) < NUM_REGS for a power-of-two bank.
  assign wIdx = awAddr_q[LSB +: IDX_W];
  assign rIdx = arAddr_q[LSB +: IDX_W];

`ifdef AXIL_PROT_CHECK_EN
  logic awProt0_q, awProt0_d;
  logic arProt0_q, arProt0_d;

  // The top index bit marks the privileged upper half of the bank.
  assign wOk = (awAddr_q[ADDR_WIDTH-1:LSB+IDX_W] == '0) && !(wIdx[IDX_W-1] && !awProt0_q);
  assign rOk = (arAddr_q[ADDR_WIDTH-1:LSB+IDX_W] == '0) && !(rIdx[IDX_W-1] && !arProt0_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awProt0_q <= 1'b0;
      arProt0_q <= 1'b0;
    end else begin
      awProt0_q <= awProt0_d;
      arProt0_q <= arProt0_d;
    end
  end

  always_comb begin
    awProt0_d = awProt0_q;
    arProt0_d = arProt0_q;
    if (wState_q == W_IDLE && awReady_q && bus.AWVALID) awProt0_d = bus.AWPROT[0];
    if (rState_q == R_IDLE && arReady_q && bus.ARVALID) arProt0_d = bus.ARPROT[0];
  end
`else
  assign wOk = (awAddr_q[ADDR_WIDTH-1:LSB+IDX_W] == '0);
  assign rOk = (arAddr_q[ADDR_WIDTH-1:LSB+IDX_W] == '0);
`endif

  // Sub-word address bits and the PROT fields are intentionally not decoded.
  logic unusedBits;
  assign unusedBits = &{1'b0, bus.AWPROT, bus.ARPROT, awAddr_q[LSB-1:0], arAddr_q[LSB-1:0]};

  axil_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .oldData_i    (regs_q[wIdx]),
    .wData_i      (wData_q),
    .wStrb_i      (wStrb_q),
    .mergedData_o (mergedData)
  );

  // Write FSM next state. AW and W are captured independently; the edge after
  // both are held performs the register update and raises BVALID. The have
  // flags distinguish "captured" from the post-reset cycle where the READYs
  // are still low.
  always_comb begin
    wState_d  = wState_q;
    awReady_d = awReady_q;
    wReady_d  = wReady_q;
    awHave_d  = awHave_q;
    wHave_d   = wHave_q;
    bValid_d  = bValid_q;
    bResp_d   = bResp_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    regWe     = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (awHave_q && wHave_q) begin
          regWe     = wOk;
          bValid_d  = 1'b1;
          bResp_d   = wOk ? RESP_OKAY : RESP_SLVERR;
          awHave_d  = 1'b0;
          wHave_d   = 1'b0;
          awReady_d = 1'b0;
          wReady_d  = 1'b0;
          wState_d  = W_RESP;
        end else begin
          if (awReady_q && bus.AWVALID) begin
            awHave_d = 1'b1;
            awAddr_d = bus.AWADDR;
          end
          if (wReady_q && bus.WVALID) begin
            wHave_d = 1'b1;
            wData_d = bus.WDATA;
            wStrb_d = bus.WSTRB;
          end
          awReady_d = !awHave_d;
          wReady_d  = !wHave_d;
        end
      end
      W_RESP: begin
        if (bus.BREADY) begin
          bValid_d  = 1'b0;
          awReady_d = 1'b1;
          wReady_d  = 1'b1;
          wState_d  = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wState_q  <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      awHave_q  <= 1'b0;
      wHave_q   <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
    end else begin
      wState_q  <= wState_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
      awHave_q  <= awHave_d;
      wHave_q   <= wHave_d;
      bValid_q  <= bValid_d;
      bResp_q   <= bResp_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (regWe) begin
      regs_q[wIdx] <= mergedData;
    end
  end

  // Read FSM next state. The AR handshake only captures the address; the
  // following edge samples the bank, so a write landing on that same edge is
  // not yet visible.
  always_comb begin
    rState_d  = rState_q;
    arReady_d = arReady_q;
    arHave_d  = arHave_q;
    rValid_d  = rValid_q;
    rResp_d   = rResp_q;
    rData_d   = rData_q;
    arAddr_d  = arAddr_q;
    case (rState_q)
      R_IDLE: begin
        if (arHave_q) begin
          rValid_d  = 1'b1;
          rData_d   = rOk ? regs_q[rIdx] : '0;
          rResp_d   = rOk ? RESP_OKAY : RESP_SLVERR;
          arHave_d  = 1'b0;
          arReady_d = 1'b0;
          rState_d  = R_DATA;
        end else if (arReady_q && bus.ARVALID) begin
          arHave_d  = 1'b1;
          arAddr_d  = bus.ARADDR;
          arReady_d = 1'b0;
        end else begin
          arReady_d = 1'b1;
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          rValid_d  = 1'b0;
          arReady_d = 1'b1;
          rState_d  = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b0;
      arHave_q  <= 1'b0;
      rValid_q  <= 1'b0;
      rResp_q   <= RESP_OKAY;
      rData_q   <= '0;
      arAddr_q  <= '0;
    end else begin
      rState_q  <= rState_d;
      arReady_q <= arReady_d;
      arHave_q  <= arHave_d;
      rValid_q  <= rValid_d;
      rResp_q   <= rResp_d;
      rData_q   <= rData_d;
      arAddr_q  <= arAddr_d;
    end
  end

  assign bus.AWREADY = awReady_q;
  assign bus.WREADY  = wReady_q;
  assign bus.BVALID  = bValid_q;
  assign bus.BRESP   = bResp_q;
  assign bus.ARREADY = arReady_q;
  assign bus.RVALID  = rValid_q;
  assign bus.RDATA   = rData_q;
  assign bus.RRESP   = rResp_q;

endmodule
